// File: rtl/serial_add_ctrl.sv
// Bit-serial-by-slice adder controller: one SLICE-bit add per RUN cycle on a
// shared ripple slice, carry held between slices, valid/ready on both sides.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             busy_o
);

    localparam int unsigned N    = WIDTH / SLICE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SLICE-1:0]       slice_s;
    logic [SLICE:0]         slice_c;
    logic [WIDTH+SLICE-1:0] sum_cat;

    // Shared slice adder: a chain of 1-bit full-add cells on the low operand bits.
    always_comb begin
        slice_s    = '0;
        slice_c    = '0;
        slice_c[0] = carry_q;
        for (int i = 0; i < SLICE; i++) begin
            slice_s[i]   = a_sh_q[i] ^ b_sh_q[i] ^ slice_c[i];
            slice_c[i+1] = (a_sh_q[i] & b_sh_q[i]) | (slice_c[i] & (a_sh_q[i] ^ b_sh_q[i]));
        end
    end

    // New slice enters at the top of the result; older slices move down.
    assign sum_cat = {slice_s, sum_q};

    // Next-state logic; flush overrides both handshakes.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (flush_i) begin
            state_d = StIdle;
            carry_d = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        a_sh_d  = a_i;
                        b_sh_d  = b_i;
                        carry_d = cin_i;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    sum_d   = sum_cat[WIDTH+SLICE-1:SLICE];
                    a_sh_d  = a_sh_q >> SLICE;
                    b_sh_d  = b_sh_q >> SLICE;
                    carry_d = slice_c[SLICE];
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_d = StDone;
                        cout_d  = slice_c[SLICE];
                        // Carry into the MSB cell vs. carry out of it.
                        ovf_d   = slice_c[SLICE-1] ^ slice_c[SLICE];
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake and status outputs decode straight from the state register.
    always_comb begin
        in_ready_o  = (state_q == StIdle);
        out_valid_o = (state_q == StDone);
        busy_o      = (state_q == StRun) || (state_q == StDone);
    end

    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed corner cases plus random
// adds, all checked against a plain-arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned SLICE = 4;
    localparam int unsigned N     = WIDTH / SLICE;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(
        .WIDTH(WIDTH),
        .SLICE(SLICE)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .cin_i      (cin_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .sum_o      (sum_o),
        .cout_o     (cout_o),
        .ovf_o      (ovf_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {ovf, cout, sum} from plain integer addition.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic c);
        logic [16:0] full;
        logic        ovf;
        full = 17'(a) + 17'(b) + 17'(c);
        ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; hold>0 keeps out_ready low that many DONE cycles
    // while a new pair (0x0001 + 0x00FE) is offered and must be ignored.
    task automatic run_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                           input int hold, input string tag);
        logic [17:0] exp;
        int          lat;
        exp         = ref_add(a, b, c);
        a_i         = a;
        b_i         = b;
        cin_i       = c;
        in_valid_i  = 1'b1;
        out_ready_i = (hold == 0);
        check({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        tick();
        in_valid_i = 1'b0;
        check({tag, "_busy_run"}, 32'(busy_o), 32'd1);
        check({tag, "_ready_run"}, 32'(in_ready_o), 32'd0);
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(N + 1));
        check({tag, "_sum"}, 32'(sum_o), 32'(exp[15:0]));
        check({tag, "_cout"}, 32'(cout_o), 32'(exp[16]));
        check({tag, "_ovf"}, 32'(ovf_o), 32'(exp[17]));
        for (int i = 0; i < hold; i++) begin
            a_i        = 16'h0001;
            b_i        = 16'h00FE;
            cin_i      = 1'b0;
            in_valid_i = 1'b1;
            tick();
            check({tag, "_hold_valid"}, 32'(out_valid_o), 32'd1);
            check({tag, "_hold_ready"}, 32'(in_ready_o), 32'd0);
            check({tag, "_hold_sum"}, 32'(sum_o), 32'(exp[15:0]));
            check({tag, "_hold_cout"}, 32'(cout_o), 32'(exp[16]));
        end
        out_ready_i = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 32'(out_valid_o), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready_o), 32'd1);
    endtask

    initial begin
        logic [31:0] r;
        logic        seen_valid;

        rst         = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        a_i         = '0;
        b_i         = '0;
        cin_i       = 1'b0;
        out_ready_i = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_cout", 32'(cout_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Directed adds.
        run_add(16'h1234, 16'h4321, 1'b0, 0, "t1");
        run_add(16'h0FFF, 16'h0001, 1'b1, 0, "t2a");
        run_add(16'hFFFF, 16'h0001, 1'b0, 0, "t2b");
        run_add(16'h7FFF, 16'h0001, 1'b0, 0, "t3a");
        run_add(16'h8000, 16'h8000, 1'b0, 0, "t3b");

        // Backpressure; the pending pair is accepted only after IDLE returns.
        run_add(16'hABCD, 16'h1111, 1'b1, 3, "t4");
        run_add(16'h0001, 16'h00FE, 1'b0, 0, "t4_next");

        // Asynchronous reset in RUN cycle 2.
        a_i        = 16'h5A5A;
        b_i        = 16'h3C3C;
        cin_i      = 1'b1;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5_in_ready", 32'(in_ready_o), 32'd1);
        check("t5_out_valid", 32'(out_valid_o), 32'd0);
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_sum", 32'(sum_o), 32'd0);
        check("t5_cout", 32'(cout_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_add(16'h0003, 16'h0004, 1'b0, 0, "t5_after");

        // Flush in RUN cycle 3; no result may appear.
        a_i        = 16'hFFFF;
        b_i        = 16'hFFFF;
        cin_i      = 1'b1;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        tick();
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t6_flush_ready", 32'(in_ready_o), 32'd1);
        check("t6_flush_busy", 32'(busy_o), 32'd0);
        seen_valid = 1'b0;
        for (int i = 0; i < N + 3; i++) begin
            if (out_valid_o) seen_valid = 1'b1;
            tick();
        end
        check("t6_no_valid", 32'(seen_valid), 32'd0);

        // Flush beats in_valid in IDLE.
        flush_i    = 1'b1;
        in_valid_i = 1'b1;
        tick();
        check("t6_flush_busy_idle", 32'(busy_o), 32'd0);
        check("t6_flush_ready_idle", 32'(in_ready_o), 32'd1);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        tick();
        check("t6_still_idle", 32'(busy_o), 32'd0);
        run_add(16'h2222, 16'h3333, 1'b0, 0, "t6_after");

        // Random operands, carry-in and backpressure.
        for (int k = 0; k < 24; k++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            r  = $urandom;
            ra = r[15:0];
            rb = r[31:16];
            r  = $urandom;
            run_add(ra, rb, r[0], int'($urandom_range(0, 2)), "rnd");
        end
        in_valid_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
